// File: rtl/cop_xfer_pkg.sv
// Shared definitions for the coprocessor transfer unit: FSM encoding,
// staging-entry layout and default parameter values.
package cop_xfer_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 3;
    localparam int unsigned DEF_NCOP  = 4;
    localparam int unsigned DEF_TMO   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } xfer_state_e;

    typedef enum logic {
        DIR_FROM = 1'b0,
        DIR_TO   = 1'b1
    } xfer_dir_e;

    // Low bits of every staging entry; sel and data sit above it: {data, sel, hdr}
    typedef struct packed {
        xfer_dir_e dir;
        logic      valid;
    } ent_hdr_t;

    localparam int unsigned ENT_VLD = 0;
    localparam int unsigned ENT_SEL = $bits(ent_hdr_t);

    function automatic int unsigned ent_bits(input int unsigned selw, input int unsigned width);
        return ENT_SEL + selw + width;
    endfunction

endpackage

// File: rtl/cop_xfer_unit_if.sv
// Issue, coprocessor-bus and register-file handshake signals of the transfer unit.
interface cop_xfer_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCOP  = 4
);
    logic                     Stall_s1;
    logic                     Kill_s1;
    logic                     MvTo_s1;
    logic                     MvFrom_s1;
    logic [$clog2(NCOP)-1:0]  CopSel_s1;
    logic [WIDTH-1:0]         BTBus_s1;
    logic [WIDTH-1:0]         CopBusOut;
    logic [NCOP-1:0]          CopBusOE;
    logic [NCOP*WIDTH-1:0]    CopBusIn;
    logic [NCOP-1:0]          CopRspValid;
    logic [WIDTH-1:0]         MemBus;
    logic                     MemBusValid;
    logic                     MemBusAck;
    logic                     Busy;
    logic                     Timeout;

    modport master (
        output Stall_s1, Kill_s1, MvTo_s1, MvFrom_s1, CopSel_s1, BTBus_s1,
               CopBusIn, CopRspValid, MemBusAck,
        input  CopBusOut, CopBusOE, MemBus, MemBusValid, Busy, Timeout
    );

    modport slave (
        input  Stall_s1, Kill_s1, MvTo_s1, MvFrom_s1, CopSel_s1, BTBus_s1,
               CopBusIn, CopRspValid, MemBusAck,
        output CopBusOut, CopBusOE, MemBus, MemBusValid, Busy, Timeout
    );
endinterface

// File: rtl/cop_stage_reg.sv
// One staging register: loads on enable, kill clears only the valid bit.
module cop_stage_reg
    import cop_xfer_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_kill,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_kill) begin
            r_q[ENT_VLD] <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/cop_xfer_unit.sv
// Coprocessor move-to/move-from transfer unit: DEPTH-stage issue staging,
// one-hot write strobes and a response/timeout FSM feeding the register file.
module cop_xfer_unit
    import cop_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned NCOP  = DEF_NCOP,
    parameter int unsigned TMO   = DEF_TMO
) (
    input  logic           Phi1,
    input  logic           Reset_s1n,
    cop_xfer_unit_if.slave bus
);
    localparam int unsigned SELW = $clog2(NCOP);
    localparam int unsigned CNTW = $clog2(TMO + 1);
    localparam int unsigned EW   = ent_bits(SELW, WIDTH);

    logic [EW-1:0]    w_stg_d [DEPTH];
    logic [EW-1:0]    w_stg_q [DEPTH];
    logic [EW-1:0]    w_iss;
    logic [EW-1:0]    w_fin;
    ent_hdr_t         w_iss_hdr;
    ent_hdr_t         w_fin_hdr;
    logic [SELW-1:0]  w_fin_sel;
    logic [WIDTH-1:0] w_fin_data;
    logic             w_adv;
    logic             w_retire;
    logic             w_fin_vld_nxt;
    logic             w_rsp_hit;
    logic [WIDTH-1:0] w_rsp_data;

    xfer_state_e      r_state, w_state_nxt;
    logic [SELW-1:0]  r_sel, w_sel_nxt;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_mem, w_mem_nxt;
    logic             w_tmo_nxt;
    logic             r_tmo;
    logic             r_mvld;
    logic             r_busy;
    logic [NCOP-1:0]  r_oe;
    logic [WIDTH-1:0] r_cop_out;

    always_comb begin
        w_iss_hdr.valid = bus.MvTo_s1 | bus.MvFrom_s1;
        w_iss_hdr.dir   = bus.MvTo_s1 ? DIR_TO : DIR_FROM;
    end
    assign w_iss = {bus.BTBus_s1, bus.CopSel_s1, w_iss_hdr};

    // Busy is registered from next-cycle values, so it is exact in the cycle it gates
    assign w_adv = !bus.Stall_s1 && !r_busy;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stg
        if (g == 0) begin : g_head
            assign w_stg_d[g] = w_iss;
        end else begin : g_body
            assign w_stg_d[g] = w_stg_q[g-1];
        end
        cop_stage_reg #(.W(EW)) u_stg (
            .clk    (Phi1),
            .rst_n  (Reset_s1n),
            .i_en   (w_adv),
            .i_kill (bus.Kill_s1),
            .i_d    (w_stg_d[g]),
            .o_q    (w_stg_q[g])
        );
    end

    assign w_fin      = w_stg_q[DEPTH-1];
    assign w_fin_hdr  = ent_hdr_t'(w_fin[ENT_SEL-1:0]);
    assign w_fin_sel  = w_fin[ENT_SEL +: SELW];
    assign w_fin_data = w_fin[ENT_SEL+SELW +: WIDTH];

    // A killed final entry is squashed rather than retired
    assign w_retire      = w_adv && w_fin_hdr.valid && !bus.Kill_s1;
    assign w_fin_vld_nxt = bus.Kill_s1 ? 1'b0
                         : (w_adv ? w_stg_d[DEPTH-1][ENT_VLD] : w_fin_hdr.valid);

    always_comb begin
        w_rsp_hit  = 1'b0;
        w_rsp_data = '0;
        for (int k = 0; k < int'(NCOP); k++) begin
            if (r_sel == SELW'(k)) begin
                w_rsp_hit  = bus.CopRspValid[k];
                w_rsp_data = bus.CopBusIn[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_mem_nxt   = r_mem;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_retire && w_fin_hdr.dir == DIR_FROM) begin
                    w_state_nxt = ST_WAIT;
                    w_sel_nxt   = w_fin_sel;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = (r_cnt == CNTW'(TMO)) ? r_cnt : r_cnt + CNTW'(1);
                // A response in the last waiting cycle beats the timeout
                if (w_rsp_hit) begin
                    w_mem_nxt   = w_rsp_data;
                    w_state_nxt = ST_HOLD;
                end else if (r_cnt == CNTW'(TMO - 1)) begin
                    w_mem_nxt   = '1;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.MemBusAck) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Phi1 or negedge Reset_s1n) begin
        if (!Reset_s1n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_mem     <= '0;
            r_tmo     <= 1'b0;
            r_mvld    <= 1'b0;
            r_busy    <= 1'b0;
            r_oe      <= '0;
            r_cop_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mem   <= w_mem_nxt;
            r_tmo   <= w_tmo_nxt;
            r_mvld  <= (w_state_nxt == ST_HOLD);
            r_busy  <= w_fin_vld_nxt && (w_state_nxt != ST_IDLE);
            if (w_retire && w_fin_hdr.dir == DIR_TO) begin
                r_oe      <= NCOP'(1) << w_fin_sel;
                r_cop_out <= w_fin_data;
            end else begin
                r_oe      <= '0;
            end
        end
    end

    assign bus.CopBusOut   = r_cop_out;
    assign bus.CopBusOE    = r_oe;
    assign bus.MemBus      = r_mem;
    assign bus.MemBusValid = r_mvld;
    assign bus.Busy        = r_busy;
    assign bus.Timeout     = r_tmo;
endmodule

// File: tb/tb_cop_xfer_unit.sv
// Self-checking bench for cop_xfer_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cop_xfer_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned NCOP  = 4;
    localparam int unsigned TMO   = 15;

    logic Phi1;
    logic Reset_s1n;
    int   vectors;
    int   miscompares;

    cop_xfer_unit_if #(.WIDTH(WIDTH), .NCOP(NCOP)) bus ();

    cop_xfer_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCOP(NCOP), .TMO(TMO)) dut (
        .Phi1      (Phi1),
        .Reset_s1n (Reset_s1n),
        .bus       (bus)
    );

    initial Phi1 = 1'b0;
    always #5 Phi1 = ~Phi1;

    // Behavioural model: staged requests as a shifting array, transfer as a phase
    typedef struct {
        bit               v;
        bit               to;
        int               sel;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t             pipe [DEPTH];
    int               phase;   // 0 no transfer, 1 awaiting response, 2 presenting data
    int               waited;
    int               tsel;
    logic [WIDTH-1:0] m_mem, m_out;
    logic [NCOP-1:0]  m_oe;
    bit               m_tmo, m_busy, m_mvld;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) pipe[i] = '{v: 0, to: 0, sel: 0, data: '0};
        phase = 0; waited = 0; tsel = 0;
        m_mem = '0; m_out = '0; m_oe = '0;
        m_tmo = 0; m_busy = 0; m_mvld = 0;
    endtask

    task automatic model_step();
        bit   adv, ret;
        ent_t fin;
        adv  = !bus.Stall_s1 && !m_busy;
        fin  = pipe[DEPTH-1];
        ret  = adv && fin.v && !bus.Kill_s1;
        m_oe = '0;
        m_tmo = 0;
        if (ret && fin.to) begin
            m_oe  = NCOP'(1) << fin.sel;
            m_out = fin.data;
        end
        if (phase == 0) begin
            if (ret && !fin.to) begin phase = 1; tsel = fin.sel; waited = 0; end
        end else if (phase == 1) begin
            waited++;
            if (bus.CopRspValid[tsel]) begin
                m_mem = bus.CopBusIn[tsel*WIDTH +: WIDTH];
                phase = 2;
            end else if (waited == int'(TMO)) begin
                m_mem = '1; m_tmo = 1; phase = 2;
            end
        end else begin
            if (bus.MemBusAck) phase = 0;
        end
        if (bus.Kill_s1) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i].v = 0;
        end else if (adv) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{v: bus.MvTo_s1 | bus.MvFrom_s1, to: bus.MvTo_s1,
                        sel: int'(bus.CopSel_s1), data: bus.BTBus_s1};
        end
        m_busy = pipe[DEPTH-1].v && (phase != 0);
        m_mvld = (phase == 2);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: DUT and model see the same inputs, outputs compared 1ns later
    task automatic cycle();
        @(posedge Phi1);
        model_step();
        #1;
        chk("CopBusOE",    64'(bus.CopBusOE),    64'(m_oe));
        chk("CopBusOut",   64'(bus.CopBusOut),   64'(m_out));
        chk("MemBus",      64'(bus.MemBus),      64'(m_mem));
        chk("MemBusValid", 64'(bus.MemBusValid), 64'(m_mvld));
        chk("Busy",        64'(bus.Busy),        64'(m_busy));
        chk("Timeout",     64'(bus.Timeout),     64'(m_tmo));
    endtask

    task automatic set_idle();
        bus.Stall_s1 = 0; bus.Kill_s1 = 0; bus.MvTo_s1 = 0; bus.MvFrom_s1 = 0;
        bus.CopSel_s1 = '0; bus.BTBus_s1 = '0; bus.CopBusIn = '0;
        bus.CopRspValid = '0; bus.MemBusAck = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oe"},   64'(bus.CopBusOE),    64'h0);
        chk({tag, "_out"},  64'(bus.CopBusOut),   64'h0);
        chk({tag, "_mem"},  64'(bus.MemBus),      64'h0);
        chk({tag, "_mvld"}, 64'(bus.MemBusValid), 64'h0);
        chk({tag, "_busy"}, 64'(bus.Busy),        64'h0);
        chk({tag, "_tmo"},  64'(bus.Timeout),     64'h0);
    endtask

    task automatic do_reset();
        Reset_s1n = 1'b0;
        set_idle();
        #20;
        chk_reset_vals("rst");
        model_reset();
        @(negedge Phi1);
        Reset_s1n = 1'b1;
    endtask

    initial begin
        bit did_mid_rst;
        vectors = 0; miscompares = 0; did_mid_rst = 0;
        Reset_s1n = 1'b0;
        set_idle();
        model_reset();

        // Move-to sel=2: strobe in cycle DEPTH only
        do_reset();
        bus.MvTo_s1 = 1; bus.CopSel_s1 = 2'd2; bus.BTBus_s1 = 32'hDEADBEEF;
        cycle();
        set_idle();
        cycle(); chk("mvto_c1_oe", 64'(bus.CopBusOE), 64'h0);
        cycle(); chk("mvto_c2_oe", 64'(bus.CopBusOE), 64'h0);
        cycle(); chk("mvto_c3_oe", 64'(bus.CopBusOE), 64'h4);
                 chk("mvto_c3_out", 64'(bus.CopBusOut), 64'hDEADBEEF);
        cycle(); chk("mvto_c4_oe", 64'(bus.CopBusOE), 64'h0);
                 chk("mvto_c4_out", 64'(bus.CopBusOut), 64'hDEADBEEF);

        // Move-from sel=1, answered in the fifth waiting cycle
        do_reset();
        bus.MvFrom_s1 = 1; bus.CopSel_s1 = 2'd1;
        cycle();
        set_idle();
        repeat (7) cycle();
        chk("mvfr_pre_mvld", 64'(bus.MemBusValid), 64'h0);
        bus.CopRspValid = 4'b0010;
        bus.CopBusIn = {32'h0, 32'h0, 32'h12345678, 32'h0};
        cycle();
        bus.CopRspValid = '0;
        chk("mvfr_mvld", 64'(bus.MemBusValid), 64'h1);
        chk("mvfr_mem",  64'(bus.MemBus),      64'h12345678);
        repeat (3) begin
            bus.CopBusIn = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            chk("mvfr_hold_mvld", 64'(bus.MemBusValid), 64'h1);
            chk("mvfr_hold_mem",  64'(bus.MemBus),      64'h12345678);
        end
        bus.MemBusAck = 1;
        cycle();
        bus.MemBusAck = 0;
        chk("mvfr_ack_mvld", 64'(bus.MemBusValid), 64'h0);

        // Move-from sel=3 with no response: timeout after TMO waiting cycles
        do_reset();
        bus.MvFrom_s1 = 1; bus.CopSel_s1 = 2'd3;
        cycle();
        set_idle();
        repeat (17) begin
            cycle();
            chk("tmo_early", 64'(bus.Timeout), 64'h0);
        end
        cycle();
        chk("tmo_pulse", 64'(bus.Timeout),     64'h1);
        chk("tmo_mem",   64'(bus.MemBus),      64'hFFFFFFFF);
        chk("tmo_mvld",  64'(bus.MemBusValid), 64'h1);
        bus.MemBusAck = 1;
        cycle();
        bus.MemBusAck = 0;
        chk("tmo_end", 64'(bus.Timeout), 64'h0);

        // Back-to-back move-froms: second waits behind the first, then completes
        do_reset();
        bus.MvFrom_s1 = 1; bus.CopSel_s1 = 2'd1;
        cycle();
        bus.CopSel_s1 = 2'd2;
        cycle();
        set_idle();
        cycle(); cycle();
        chk("b2b_busy_wait", 64'(bus.Busy), 64'h1);
        bus.CopRspValid = 4'b0010;
        bus.CopBusIn = {32'h0, 32'h0, 32'h11111111, 32'h0};
        cycle();
        bus.CopRspValid = '0;
        chk("b2b_first_mem", 64'(bus.MemBus), 64'h11111111);
        cycle(); cycle();
        chk("b2b_busy_hold", 64'(bus.Busy), 64'h1);
        bus.MemBusAck = 1;
        cycle();
        bus.MemBusAck = 0;
        chk("b2b_busy_rel", 64'(bus.Busy), 64'h0);
        cycle();
        bus.CopRspValid = 4'b0100;
        bus.CopBusIn = {32'h0, 32'h22222222, 32'h0, 32'h0};
        cycle();
        bus.CopRspValid = '0;
        chk("b2b_second_mvld", 64'(bus.MemBusValid), 64'h1);
        chk("b2b_second_mem",  64'(bus.MemBus),      64'h22222222);
        bus.MemBusAck = 1;
        cycle();
        bus.MemBusAck = 0;

        // Kill under stall squashes a staged move-to
        do_reset();
        bus.MvTo_s1 = 1; bus.CopSel_s1 = 2'd0; bus.BTBus_s1 = 32'hCAFEF00D;
        cycle();
        set_idle();
        bus.Kill_s1 = 1; bus.Stall_s1 = 1;
        cycle();
        set_idle();
        repeat (6) begin
            cycle();
            chk("kill_oe", 64'(bus.CopBusOE), 64'h0);
        end

        // Wrong-channel responses ignored; right one in the last cycle beats timeout
        do_reset();
        bus.MvFrom_s1 = 1; bus.CopSel_s1 = 2'd2;
        cycle();
        set_idle();
        bus.CopRspValid = 4'b0001;
        bus.CopBusIn = {32'h0, 32'h0, 32'h0, 32'hBAD0BAD0};
        repeat (17) begin
            cycle();
            chk("race_wait_mvld", 64'(bus.MemBusValid), 64'h0);
        end
        bus.CopRspValid = 4'b0100;
        bus.CopBusIn = {32'h0, 32'hC0FFEE02, 32'h0, 32'hBAD0BAD0};
        cycle();
        bus.CopRspValid = '0;
        chk("race_mvld", 64'(bus.MemBusValid), 64'h1);
        chk("race_mem",  64'(bus.MemBus),      64'hC0FFEE02);
        chk("race_tmo",  64'(bus.Timeout),     64'h0);

        // Randomized traffic, with one asynchronous reset while a move-from waits
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.Stall_s1    = ($urandom_range(0, 9) == 0);
            bus.Kill_s1     = ($urandom_range(0, 39) == 0);
            bus.MvTo_s1     = ($urandom_range(0, 3) == 0);
            bus.MvFrom_s1   = ($urandom_range(0, 3) == 0);
            bus.CopSel_s1   = 2'($urandom);
            bus.BTBus_s1    = $urandom;
            bus.CopBusIn    = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < int'(NCOP); k++) bus.CopRspValid[k] = ($urandom_range(0, 19) == 0);
            bus.MemBusAck   = ($urandom_range(0, 2) == 0);
            cycle();
            if (!did_mid_rst && n >= 1500 && phase == 1) begin
                did_mid_rst = 1;
                #1 Reset_s1n = 1'b0;
                #1 chk_reset_vals("midrst");
                model_reset();
                #1 Reset_s1n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cop_xfer_unit.md
COP_XFER_UNIT -- requirements
Module: cop_xfer_unit

Interface
REQ-001 Parameter WIDTH, default 32: data path width in bits.
REQ-002 Parameter DEPTH, default 3, minimum 1: number of staging stages between issue and coprocessor bus.
REQ-003 Parameter NCOP, default 4, minimum 2: number of coprocessor channels.
REQ-004 Parameter TMO, default 15, minimum 1: move-from response timeout in cycles.
REQ-005 Phi1  in  1  the single clock; all state updates on its rising edge.
REQ-006 Reset_s1n  in  1  asynchronous, active-low reset.
REQ-007 Stall_s1  in  1  external pipeline hold.
REQ-008 Kill_s1  in  1  squash all staged requests.
REQ-009 MvTo_s1  in  1  issue move-to-coprocessor.
REQ-010 MvFrom_s1  in  1  issue move-from-coprocessor.
REQ-011 CopSel_s1  in  clog2(NCOP)  target channel.
REQ-012 BTBus_s1  in  WIDTH  move-to data from register file.
REQ-013 CopBusOut  out  WIDTH  shared coprocessor write data.
REQ-014 CopBusOE  out  NCOP  one-hot write strobe per channel.
REQ-015 CopBusIn  in  NCOP*WIDTH  per-channel read data; channel k is bits [k*WIDTH +: WIDTH].
REQ-016 CopRspValid  in  NCOP  per-channel read response valid.
REQ-017 MemBus  out  WIDTH  read data to register file.
REQ-018 MemBusValid  out  1  MemBus holds valid data.
REQ-019 MemBusAck  in  1  consumer accepts MemBus.
REQ-020 Busy  out  1  internal stall; upstream must hold issue.
REQ-021 Timeout  out  1  one-cycle pulse on response timeout.

Function
REQ-022 Each stage SHALL hold {valid, dir, sel, data}; stage 0 loads on MvTo_s1 or MvFrom_s1; MvTo_s1 has priority when both are asserted.
REQ-023 Stages SHALL advance together when Stall_s1=0 and Busy=0; otherwise all stages hold, and issue is ignored while held.
REQ-024 Kill_s1 SHALL clear every valid bit next edge, overriding Stall_s1 and a same-cycle issue; it SHALL NOT affect the FSM.
REQ-025 A move-to in the final stage while advancing SHALL drive CopBusOut=data and CopBusOE=one-hot(sel) for exactly one cycle; otherwise CopBusOE=0 and CopBusOut holds its last value.
REQ-026 Move-to latency: issue at edge t, no stalls -> CopBusOE asserted during cycle t+DEPTH.
REQ-027 FSM states IDLE, WAIT, HOLD; a move-from retiring from the final stage moves IDLE->WAIT, latching sel and clearing the cycle counter.
REQ-028 WAIT: when CopRspValid[sel]=1, capture that channel's CopBusIn into MemBus and go to HOLD; responses on other channels are ignored.
REQ-029 WAIT: counter increments each cycle; reaching TMO without a response -> Timeout pulse, MemBus={WIDTH{1}}, go to HOLD.
REQ-030 If a response and timeout coincide, the response SHALL win and Timeout stays 0.
REQ-031 HOLD: MemBusValid=1 until MemBusAck=1, then go to IDLE next edge; MemBus is stable throughout HOLD.
REQ-032 Busy SHALL be 1 while a valid final-stage entry exists and FSM!=IDLE.
REQ-033 Counter width SHALL be clog2(TMO+1) and SHALL saturate, never wrap.

Reset
REQ-034 On reset: all valid bits 0, FSM IDLE, counter 0, CopBusOE 0, CopBusOut 0, MemBus 0, MemBusValid 0, Busy 0, Timeout 0.
REQ-035 Reset asserted mid-transfer SHALL abandon it with no Timeout pulse or strobe.

Structure
REQ-036 Package cop_xfer_pkg SHALL hold the FSM state encoding, stage-entry record layout and default parameter constants.
REQ-037 One sub-module, cop_stage_reg (one enable/kill stage register), SHALL be instantiated DEPTH times.

Verification
REQ-038 Reset, MvTo_s1 sel=2 data=0xDEADBEEF, no stall -> CopBusOE=4'b0100 and CopBusOut=0xDEADBEEF in cycle 3, single cycle.
REQ-039 MvFrom_s1 sel=1; channel 1 responds 5 cycles later with 0x12345678 -> MemBusValid=1, MemBus=0x12345678 held until MemBusAck.
REQ-040 MvFrom_s1 sel=3, no response -> Timeout pulse after 15 WAIT cycles, MemBus=0xFFFFFFFF.
REQ-041 Two back-to-back move-froms -> Busy=1 until first is acked; second enters WAIT afterwards, none lost.
REQ-042 Issue MvTo, Kill_s1 next cycle with Stall_s1=1 -> no CopBusOE pulse ever.
REQ-043 Channel 0 response during WAIT for sel=2, then channel 2 response on cycle TMO -> capture channel 2 data, Timeout=0.
